// File: rtl/stage_ic.sv
// Purpose: complete stage; buffers finished instructions from execute in an in-order FIFO and writes them back on CDB/ROB.
// Latency: one cycle from push to presentation; zero cycles with IC_BYPASS_EN when the buffer is empty and the CDB is granted.
// Backpressure: ic_ready = (count != DEPTH) and is independent of cdb_grant; outputs hold until cdb_grant pops the head.
//
// Optional feature macro: IC_BYPASS_EN (empty-buffer bypass from execute straight to CDB/ROB).
// Ports:
//   clock, reset_n                     clock, asynchronous active-low reset
//   ex_*  / ic_ready                   finished instruction from execute, accept indication
//   cdb_grant, flush                   arbiter grant for the head entry, mispredict squash
//   cdb_valid/tag/data                 tag/data wakeup and writeback broadcast
//   rob_cmpl_valid/idx, rob_take_branch, rob_target, rob_halt, rob_illegal   ROB completion
//   occupancy                          current entry count
module stage_ic #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int ROB_W = 5
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       ex_valid,
    input  logic [XLEN-1:0]            ex_result,
    input  logic [TAG_W-1:0]           ex_dest_tag,
    input  logic                       ex_dest_valid,
    input  logic [ROB_W-1:0]           ex_rob_idx,
    input  logic                       ex_take_branch,
    input  logic                       ex_halt,
    input  logic                       ex_illegal,
    output logic                       ic_ready,
    input  logic                       cdb_grant,
    input  logic                       flush,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [XLEN-1:0]            cdb_data,
    output logic                       rob_cmpl_valid,
    output logic [ROB_W-1:0]           rob_cmpl_idx,
    output logic                       rob_take_branch,
    output logic [XLEN-1:0]            rob_target,
    output logic                       rob_halt,
    output logic                       rob_illegal,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [XLEN-1:0]  result;
        logic [TAG_W-1:0] dest_tag;
        logic             dest_valid;
        logic [ROB_W-1:0] rob_idx;
        logic             take_branch;
        logic             halt;
        logic             illegal;
    } entry_t;

    entry_t             mem_q   [DEPTH];
    entry_t             mem_d   [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    entry_t in_entry;
    entry_t out_entry;
    logic   out_vld;
    logic   empty;
    logic   byp_take;
    logic   push;
    logic   pop;

    assign in_entry = '{result:      ex_result,
                        dest_tag:    ex_dest_tag,
                        dest_valid:  ex_dest_valid,
                        rob_idx:     ex_rob_idx,
                        take_branch: ex_take_branch,
                        halt:        ex_halt,
                        illegal:     ex_illegal};

    assign empty    = (count_q == '0);
    // Ready only looks at the registered count, so grant never reaches ready combinationally.
    assign ic_ready = (count_q != CNT_W'(DEPTH));

`ifdef IC_BYPASS_EN
    // Empty buffer with a grant: execute result goes out this cycle and is never stored.
    assign byp_take = empty && ex_valid && cdb_grant && !flush;
`else
    assign byp_take = 1'b0;
`endif

    assign push = ex_valid && ic_ready && !flush && !byp_take;
    assign pop  = cdb_grant && !empty && !flush;

    // Next-state computation for storage, pointers and count.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            // Squash everything, including any same-cycle push or pop.
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_d]   = in_entry;
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + PTR_W'(1);
            end
            if (pop) begin
                // Clear only if the same slot is not being refilled this cycle (cannot
                // happen unless full, where push is blocked), kept explicit for clarity.
                if (!(push && (tail_q == head_q))) begin
                    valid_d[head_q] = 1'b0;
                end
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Head presentation; everything reads zero when nothing is presented.
    always_comb begin
        out_entry = '0;
        out_vld   = 1'b0;
        if (!empty && valid_q[head_q] && !flush) begin
            out_entry = mem_q[head_q];
            out_vld   = 1'b1;
        end
`ifdef IC_BYPASS_EN
        else if (empty && ex_valid && !flush) begin
            // Mirror execute while empty; without a grant the entry is also pushed.
            out_entry = in_entry;
            out_vld   = 1'b1;
        end
`endif
    end

    assign cdb_valid       = out_vld && out_entry.dest_valid && (out_entry.dest_tag != '0);
    assign cdb_tag         = out_entry.dest_tag;
    assign cdb_data        = out_entry.result;
    assign rob_cmpl_valid  = out_vld;
    assign rob_cmpl_idx    = out_entry.rob_idx;
    assign rob_take_branch = out_entry.take_branch;
    assign rob_target      = out_entry.result;
    assign rob_halt        = out_entry.halt;
    assign rob_illegal     = out_entry.illegal;
    assign occupancy       = count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_stage_ic.sv
module tb_stage_ic;

    logic        clock;
    logic        reset_n;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [5:0]  ex_dest_tag;
    logic        ex_dest_valid;
    logic [4:0]  ex_rob_idx;
    logic        ex_take_branch;
    logic        ex_halt;
    logic        ex_illegal;
    logic        ic_ready;
    logic        cdb_grant;
    logic        flush;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        rob_cmpl_valid;
    logic [4:0]  rob_cmpl_idx;
    logic        rob_take_branch;
    logic [31:0] rob_target;
    logic        rob_halt;
    logic        rob_illegal;
    logic [2:0]  occupancy;

    int errors = 0;
    int checks = 0;

    stage_ic #(.XLEN(32), .DEPTH(4), .TAG_W(6), .ROB_W(5)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .ex_valid        (ex_valid),
        .ex_result       (ex_result),
        .ex_dest_tag     (ex_dest_tag),
        .ex_dest_valid   (ex_dest_valid),
        .ex_rob_idx      (ex_rob_idx),
        .ex_take_branch  (ex_take_branch),
        .ex_halt         (ex_halt),
        .ex_illegal      (ex_illegal),
        .ic_ready        (ic_ready),
        .cdb_grant       (cdb_grant),
        .flush           (flush),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_data        (cdb_data),
        .rob_cmpl_valid  (rob_cmpl_valid),
        .rob_cmpl_idx    (rob_cmpl_idx),
        .rob_take_branch (rob_take_branch),
        .rob_target      (rob_target),
        .rob_halt        (rob_halt),
        .rob_illegal     (rob_illegal),
        .occupancy       (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [5:0] tag,
                         input logic dv, input logic [4:0] rob, input logic br,
                         input logic hlt, input logic ill, input logic gnt, input logic fl);
        ex_valid       = v;
        ex_result      = res;
        ex_dest_tag    = tag;
        ex_dest_valid  = dv;
        ex_rob_idx     = rob;
        ex_take_branch = br;
        ex_halt        = hlt;
        ex_illegal     = ill;
        cdb_grant      = gnt;
        flush          = fl;
    endtask

    task automatic idle(input logic gnt);
        drive(1'b0, 32'h0, 6'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, gnt, 1'b0);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle(1'b0);

        // Reset state
        #2;
        chk("rst_ready",   ic_ready, 1);
        chk("rst_cdb_vld", cdb_valid, 0);
        chk("rst_rob_vld", rob_cmpl_valid, 0);
        chk("rst_occ",     occupancy, 0);
        chk("rst_data",    cdb_data, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        #2;
        chk("idle_ready",   ic_ready, 1);
        chk("idle_cdb_vld", cdb_valid, 0);
        chk("idle_occ",     occupancy, 0);
        tick();

        // Single op with grant held
        drive(1'b1, 32'h2A, 6'd5, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
`ifdef IC_BYPASS_EN
        chk("single_c0_vld", cdb_valid, 1);
        tick();
        idle(1'b1);
        #2;
        chk("single_c1_occ", occupancy, 0);
`else
        chk("single_c0_vld", cdb_valid, 0);
        tick();
        idle(1'b1);
        #2;
        chk("single_cdb_vld", cdb_valid, 1);
        chk("single_tag",     cdb_tag, 5);
        chk("single_data",    cdb_data, 32'h2A);
        chk("single_rob_vld", rob_cmpl_valid, 1);
        chk("single_rob_idx", rob_cmpl_idx, 3);
        chk("single_occ1",    occupancy, 1);
        tick();
        #2;
        chk("single_occ0",  occupancy, 0);
        chk("single_after", cdb_valid, 0);
`endif
        tick();

        // Back-pressure: five pushes with no grant, the fifth is dropped
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'(i * 16), 6'(i), 1'b1, 5'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            #2;
            chk($sformatf("bp_ready_%0d", i), ic_ready, (i <= 4) ? 1 : 0);
            tick();
        end
        idle(1'b0);
        #2;
        chk("bp_occ_full", occupancy, 4);
        chk("bp_ready0",   ic_ready, 0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            idle(1'b1);
            #2;
            chk($sformatf("bp_tag_%0d", i),  cdb_tag, i);
            chk($sformatf("bp_data_%0d", i), cdb_data, i * 16);
            chk($sformatf("bp_rdy_%0d", i),  ic_ready, (i == 1) ? 0 : 1);
            tick();
        end
        idle(1'b0);
        #2;
        chk("bp_drained", occupancy, 0);
        chk("bp_no_vld",  rob_cmpl_valid, 0);
        tick();

        // Tag 0 branch, halt/illegal, and non-writing entry with nonzero tag
        drive(1'b1, 32'h100, 6'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h55, 6'd9, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h77, 6'd4, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            idle(1'b0);
            #2;
            chk($sformatf("br_rob_vld_%0d", k), rob_cmpl_valid, 1);
            chk($sformatf("br_taken_%0d", k),   rob_take_branch, 1);
            chk($sformatf("br_target_%0d", k),  rob_target, 32'h100);
            chk($sformatf("br_cdb_vld_%0d", k), cdb_valid, 0);
            chk($sformatf("br_idx_%0d", k),     rob_cmpl_idx, 7);
            tick();
        end
        idle(1'b1);
        tick();
        idle(1'b1);
        #2;
        chk("halt_flag",  rob_halt, 1);
        chk("ill_flag",   rob_illegal, 1);
        chk("halt_cdb",   cdb_valid, 1);
        chk("halt_tag",   cdb_tag, 9);
        chk("halt_br",    rob_take_branch, 0);
        tick();
        idle(1'b1);
        #2;
        chk("nodst_cdb",  cdb_valid, 0);
        chk("nodst_rob",  rob_cmpl_valid, 1);
        chk("nodst_idx",  rob_cmpl_idx, 9);
        chk("nodst_halt", rob_halt, 0);
        tick();

        // Flush with a same-cycle push and grant
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i), 6'(10 + i), 1'b1, 5'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'hDD, 6'd13, 1'b1, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        chk("fl_cdb_vld", cdb_valid, 0);
        chk("fl_rob_vld", rob_cmpl_valid, 0);
        chk("fl_occ_pre", occupancy, 3);
        tick();
        idle(1'b0);
        #2;
        chk("fl_occ",     occupancy, 0);
        chk("fl_rob_vld2", rob_cmpl_valid, 0);
        chk("fl_ready",   ic_ready, 1);
        tick();

        // Steady simultaneous push/pop across pointer wrap
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(20 + i), 6'(20 + i), 1'b1, 5'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'(23 + k), 6'(23 + k), 1'b1, 5'(3 + k), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            #2;
            chk($sformatf("wrap_tag_%0d", k), cdb_tag, 20 + k);
            chk($sformatf("wrap_occ_%0d", k), occupancy, 3);
            tick();
        end
        idle(1'b0);
        #2;
        chk("wrap_occ_end", occupancy, 3);
        chk("wrap_head",    cdb_tag, 30);
        tick();
        // Drain the remaining three in order
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            #2;
            chk($sformatf("drain_tag_%0d", k), cdb_tag, 30 + k);
            tick();
        end
        idle(1'b0);
        #2;
        chk("drain_occ", occupancy, 0);
        tick();

        // Empty buffer push with grant
        drive(1'b1, 32'hBEEF, 6'd33, 1'b1, 5'd17, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
`ifdef IC_BYPASS_EN
        chk("byp_cdb_vld", cdb_valid, 1);
        chk("byp_tag",     cdb_tag, 33);
        chk("byp_data",    cdb_data, 32'hBEEF);
        tick();
        idle(1'b0);
        #2;
        chk("byp_occ",     occupancy, 0);
`else
        chk("nobyp_cdb_vld", cdb_valid, 0);
        tick();
        idle(1'b1);
        #2;
        chk("nobyp_tag",   cdb_tag, 33);
        chk("nobyp_idx",   rob_cmpl_idx, 17);
        tick();
        idle(1'b0);
        #2;
        chk("nobyp_occ",   occupancy, 0);
`endif
        tick();

        // Mid-stream asynchronous reset discards entries
        drive(1'b1, 32'h1, 6'd1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        idle(1'b0);
        #2;
        chk("mid_occ_pre", occupancy, 2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_vld", rob_cmpl_valid, 0);
        chk("mid_rst_rdy", ic_ready, 1);
        tick();
        reset_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stage_ic.md
Name: stage_ic

Overview:
- Complete stage, directly downstream of the execute stage.
- Accepts one finished instruction per cycle from execute and buffers it in a small in-order FIFO.
- Sends the oldest entry to the CDB (tag and data wakeup/writeback) and to the ROB (completion, branch outcome) when the CDB arbiter grants it.
- Back-pressures execute when the buffer is full.

Parameters:
- XLEN, 32, datapath width.
- DEPTH, 4, completion buffer entries; must be a power of 2 and at least 2.
- TAG_W, 6, physical register tag width.
- ROB_W, 5, ROB index width.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute result present this cycle
- ex_result  in  XLEN  ALU/mult/load result, or branch target
- ex_dest_tag  in  TAG_W  destination physical register
- ex_dest_valid  in  1  instruction writes a register
- ex_rob_idx  in  ROB_W  ROB entry of the instruction
- ex_take_branch  in  1  resolved branch taken
- ex_halt  in  1  halt instruction
- ex_illegal  in  1  illegal instruction
- ic_ready  out  1  buffer can accept an entry this cycle
- cdb_grant  in  1  CDB arbiter grants this stage this cycle
- flush  in  1  mispredict squash
- cdb_valid  out  1  tag/data broadcast valid
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  XLEN  broadcast data
- rob_cmpl_valid  out  1  ROB completion valid
- rob_cmpl_idx  out  ROB_W  completing ROB entry
- rob_take_branch  out  1  branch outcome
- rob_target  out  XLEN  branch target (head result)
- rob_halt  out  1  head halt flag
- rob_illegal  out  1  head illegal flag
- occupancy  out  $clog2(DEPTH+1)  current entry count

Behaviour:
- Storage: DEPTH-entry circular FIFO. Each entry holds {result, dest_tag, dest_valid, rob_idx, take_branch, halt, illegal}. head/tail pointers are log2(DEPTH) bits and wrap naturally. count is held in its own register.
- Reset (reset_n low, asynchronous): head = tail = count = 0, entries' valid cleared.
  - All outputs are 0, except ic_ready = 1.
  - Reset asserted mid-stream discards all entries immediately.
- ic_ready = (count != DEPTH). It does not depend on cdb_grant in the same cycle, so there is no combinational grant-to-ready path.
- Push: when ex_valid && ic_ready && !flush, write the entry at tail; tail++ at the clock edge.
- ex_valid while full (ic_ready = 0): the input is ignored. Execute must hold it; the buffer does not change.
- Head presentation (combinational from head entry), active only when count != 0 and !flush:
  - rob_cmpl_valid = 1, with rob_* fields driven from the head entry.
  - cdb_valid = dest_valid && dest_tag != 0; cdb_tag and cdb_data driven from the head entry.
  - With count == 0 or flush high, all *_valid outputs are 0 and data outputs are 0.
- Pop: when cdb_grant && count != 0 && !flush, head++ at the clock edge.
  - Outputs are only consumed by CDB/ROB in a granted cycle.
  - Ungranted cycles hold the head and present the same values again.
- Simultaneous push and pop: count unchanged, both pointers advance. This also applies when count == DEPTH-1.
- Full with grant: the pop occurs, ic_ready stays 0 this cycle and rises the next cycle.
- Flush: at the next edge head = tail = count = 0. Any same-cycle push or pop is discarded.
- Latency: an entry pushed at edge N is presented on CDB/ROB in cycle N+1 at the earliest (baseline, no bypass).
- Ordering: strictly in execute-completion order. There is no reordering.
- occupancy = count.

Optional Feature:
- Macro: IC_BYPASS_EN.
- Defined: when count == 0, ex_valid, cdb_grant and !flush hold together, the execute inputs drive CDB/ROB outputs combinationally in the same cycle. The entry is not written, and tail/count do not change, giving zero-cycle latency.
  - When count == 0 and cdb_grant is low, the entry is pushed normally.
  - When count == 0, the outputs mirror the ex_* inputs whenever ex_valid.
- Undefined: no bypass. Minimum latency is 1 cycle, and outputs depend only on registered state plus flush.

Test Plan:
- Reset then idle: reset_n 0→1 with no inputs → all valids 0, ic_ready 1, occupancy 0.
- Single op: push {result 0x0000_002A, tag 5, rob 3} with cdb_grant held 1 → next cycle cdb_valid 1, cdb_tag 5, cdb_data 0x2A, rob_cmpl_idx 3; the following cycle occupancy 0.
- Back-pressure: five consecutive pushes with tags 1..5 and cdb_grant 0 → ic_ready drops after the 4th push, the 5th is ignored, occupancy 4. Then grant 4 cycles → tags broadcast 1,2,3,4 in order, ic_ready 1 after the first pop.
- Tag 0 and branch: push {dest_valid 1, tag 0, take_branch 1, result 0x100} → rob_cmpl_valid 1, rob_take_branch 1, rob_target 0x100, cdb_valid 0.
- Flush: fill 3 entries, then flush together with ex_valid and cdb_grant → next cycle occupancy 0, no broadcast in the flush cycle, the pushed op is lost.
- Wrap and simultaneous push/pop: hold count at 3 with push and grant every cycle for 10 cycles → count stays 3 and tags come out in exact input order across pointer wrap. With IC_BYPASS_EN and an empty buffer, a push plus grant broadcasts in the same cycle and occupancy stays 0.
